// File: rtl/r5fp_add_arb_if.sv
// r5fp_add_arb_if: requester, datapath and response signals of the shared R5FP add arbiter.
// slave = arbiter side, master = environment side (requesters, datapath, consumer).
interface r5fp_add_arb_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned SIG_W = 6,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned FP_W = EXP_W + SIG_W + 1;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ*3-1:0]    req_rnd;

  logic                 dp_valid;
  logic [FP_W-1:0]      dp_a;
  logic [FP_W-1:0]      dp_b;
  logic [2:0]           dp_rnd;
  logic [FP_W-1:0]      dp_z;
  logic [7:0]           dp_status;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [FP_W-1:0]      rsp_z;
  logic [7:0]           rsp_status;

  modport slave (
    input  req_valid, req_a, req_b, req_rnd, dp_z, dp_status, rsp_ready,
    output req_ready, dp_valid, dp_a, dp_b, dp_rnd, rsp_valid, rsp_id, rsp_z, rsp_status
  );

  modport master (
    output req_valid, req_a, req_b, req_rnd, dp_z, dp_status, rsp_ready,
    input  req_ready, dp_valid, dp_a, dp_b, dp_rnd, rsp_valid, rsp_id, rsp_z, rsp_status
  );
endinterface

// File: rtl/r5fp_add_arb.sv
// r5fp_add_arb: round-robin scheduler sharing one fixed-latency R5FP add datapath among NREQ
// requesters. Tags ride a LAT-deep pipe alongside the datapath; results land in a credit-protected
// FIFO and leave in issue order with the requester id.
// Optional: define R5FP_ADD_ARB_STATS_EN to add saturating per-requester grant and stall counters.
module r5fp_add_arb #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned SIG_W  = 6,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LAT    = 2,
  parameter int unsigned FIFO_D = 4
) (
  input  logic clk,
  input  logic reset,
  r5fp_add_arb_if.slave bus
`ifdef R5FP_ADD_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grant,
  output logic [15:0]        stat_stall
`endif
);
  localparam int unsigned FP_W = EXP_W + SIG_W + 1;
  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned PW   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int unsigned CW   = $clog2(FIFO_D + 1);

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [FP_W-1:0] z;
    logic [7:0]      status;
  } entry_t;

  logic [IDW-1:0]  rrPtr;
  logic [CW-1:0]   credCnt;
  logic [NREQ-1:0] grantVec;
  logic [IDW-1:0]  grantId;
  logic            grantHit;
  logic [IDW-1:0]  cand;
  int unsigned     sIdx;

  logic [FP_W-1:0] muxA;
  logic [FP_W-1:0] muxB;
  logic [2:0]      muxRnd;

  logic            dpValid;
  logic [FP_W-1:0] dpA;
  logic [FP_W-1:0] dpB;
  logic [2:0]      dpRnd;

  logic [LAT-1:0]  tagVld;
  logic [IDW-1:0]  tagId [LAT];

  entry_t          fifoMem [FIFO_D];
  entry_t          pushEntry;
  entry_t          head;
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   fifoCnt;
  logic            push;
  logic            pop;
  logic            rspValid;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick of the first valid requester at or after rrPtr while credits remain
  always_comb begin
    grantVec = '0;
    grantId  = '0;
    grantHit = 1'b0;
    cand     = '0;
    sIdx     = 0;
    if (!reset && credCnt != '0) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        sIdx = 32'(rrPtr) + k;
        if (sIdx >= NREQ) sIdx = sIdx - NREQ;
        cand = IDW'(sIdx);
        if (!grantHit && bus.req_valid[cand]) begin
          grantHit = 1'b1;
          grantId  = cand;
        end
      end
      if (grantHit) grantVec[grantId] = 1'b1;
    end
  end

  // Operand mux driven by the one-hot grant
  always_comb begin
    muxA   = '0;
    muxB   = '0;
    muxRnd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grantVec[i]) begin
        muxA   = bus.req_a[i*FP_W +: FP_W];
        muxB   = bus.req_b[i*FP_W +: FP_W];
        muxRnd = bus.req_rnd[i*3 +: 3];
      end
    end
  end

  // Round-robin pointer moves just past the winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (grantHit) begin
      rrPtr <= (grantId == IDW'(NREQ - 1)) ? '0 : grantId + IDW'(1);
    end
  end

  // Credits cover in-flight ops plus FIFO occupancy so a push always finds room
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credCnt <= CW'(FIFO_D);
    end else if (grantHit && !pop) begin
      credCnt <= credCnt - CW'(1);
    end else if (!grantHit && pop) begin
      credCnt <= credCnt + CW'(1);
    end
  end

  // Registered issue to the datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dpValid <= 1'b0;
      dpA     <= '0;
      dpB     <= '0;
      dpRnd   <= '0;
    end else begin
      dpValid <= grantHit;
      if (grantHit) begin
        dpA   <= muxA;
        dpB   <= muxB;
        dpRnd <= muxRnd;
      end
    end
  end

  // Tag pipe tracks which requester owns the result in each datapath stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tagVld <= '0;
      for (int unsigned i = 0; i < LAT; i++) tagId[i] <= '0;
    end else begin
      tagVld[0] <= grantHit;
      tagId[0]  <= grantId;
      for (int unsigned i = 1; i < LAT; i++) begin
        tagVld[i] <= tagVld[i-1];
        tagId[i]  <= tagId[i-1];
      end
    end
  end

  assign push      = tagVld[LAT-1];
  assign rspValid  = (fifoCnt != '0);
  assign pop       = rspValid && bus.rsp_ready;
  assign pushEntry = '{id: tagId[LAT-1], z: bus.dp_z, status: bus.dp_status};
  assign head      = fifoMem[rdPtr];

  // Result storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= pushEntry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (push) wrPtr <= ptrInc(wrPtr);
      if (pop)  rdPtr <= ptrInc(rdPtr);
      if (push && !pop) begin
        fifoCnt <= fifoCnt + CW'(1);
      end else if (pop && !push) begin
        fifoCnt <= fifoCnt - CW'(1);
      end
    end
  end

  assign bus.req_ready  = grantVec;
  assign bus.dp_valid   = dpValid;
  assign bus.dp_a       = dpA;
  assign bus.dp_b       = dpB;
  assign bus.dp_rnd     = dpRnd;
  assign bus.rsp_valid  = rspValid;
  assign bus.rsp_id     = rspValid ? head.id     : '0;
  assign bus.rsp_z      = rspValid ? head.z      : '0;
  assign bus.rsp_status = rspValid ? head.status : '0;

`ifdef R5FP_ADD_ARB_STATS_EN
  logic [15:0] grantCnt [NREQ];
  logic [15:0] stallCnt;

  // Saturating per-requester grant and stall counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) grantCnt[i] <= '0;
      stallCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grantVec[i] && grantCnt[i] != 16'hFFFF) grantCnt[i] <= grantCnt[i] + 16'd1;
      end
      if (|bus.req_valid && !grantHit && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
    end
  end

  // Flatten grant counters onto the output bus
  always_comb begin
    stat_grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) stat_grant[i*16 +: 16] = grantCnt[i];
  end

  assign stat_stall = stallCnt;
`endif
endmodule

// File: tb/tb_r5fp_add_arb.sv
// tb_r5fp_add_arb: directed vector table, hand-written corner sequences and a randomized run
// checked against a transaction-level model (pointer, outstanding count, expected-result queue).
module tb_r5fp_add_arb;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned SIG_W  = 6;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned LAT    = 2;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned FP_W   = EXP_W + SIG_W + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  r5fp_add_arb_if #(.EXP_W(EXP_W), .SIG_W(SIG_W), .NREQ(NREQ)) bus ();

`ifdef R5FP_ADD_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grant;
  logic [15:0]        stat_stall;
`endif

  r5fp_add_arb #(.EXP_W(EXP_W), .SIG_W(SIG_W), .NREQ(NREQ), .LAT(LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef R5FP_ADD_ARB_STATS_EN
    ,
    .stat_grant(stat_grant),
    .stat_stall(stat_stall)
`endif
  );

  // Stand-in datapath: doubles equal normal operands, propagates NaN a, otherwise a keyed mix
  function automatic logic [FP_W+7:0] dpFunc(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b,
                                             input logic [2:0] rnd);
    if (a[10:6] == 5'h1F) return {8'h10, a};
    if (a == b && a[10:6] != 5'h00) return {8'h00, a + 12'h040};
    return {a[7:0] ^ b[7:0] ^ {5'b0, rnd}, a ^ {b[5:0], b[11:6]} ^ {9'b0, rnd}};
  endfunction

  // Result appears LAT-1 cycles after the issue cycle; garbage when nothing was issued
  logic [FP_W+7:0] dpRes;
  always @(posedge clk) begin
    if (bus.dp_valid) dpRes <= dpFunc(bus.dp_a, bus.dp_b, bus.dp_rnd);
    else              dpRes <= 20'($urandom);
  end
  assign bus.dp_z      = dpRes[FP_W-1:0];
  assign bus.dp_status = dpRes[FP_W+7:FP_W];

  typedef struct {
    int              id;
    logic [FP_W-1:0] z;
    logic [7:0]      st;
    int              rdy;
  } exp_t;

  typedef struct {
    int              id;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [2:0]      rnd;
    logic [FP_W-1:0] z;
    logic [7:0]      st;
  } vec_t;

  exp_t            q[$];
  vec_t            vecs[5];
  int              mPtr, mOut, cyc, checks, errors, dutIssues;
  bit              useModel;
  logic [NREQ-1:0] lastGrant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    q.delete();
    mPtr = 0;
    mOut = 0;
  endtask

  // Compare DUT against the transaction model for the cycle about to be clocked, then advance it
  task automatic modelCheck();
    logic [NREQ-1:0] eg;
    int              g;
    bit              ev;
    exp_t            e;
    eg = '0;
    g  = -1;
    if (mOut < int'(FIFO_D)) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        if (g < 0 && bus.req_valid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    if (ev && bus.rsp_valid) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_z", 32'(bus.rsp_z), 32'(q[0].z));
      chk("rsp_status", 32'(bus.rsp_status), 32'(q[0].st));
    end
    if (ev && bus.rsp_ready) begin
      void'(q.pop_front());
      mOut--;
    end
    if (g >= 0) begin
      e.id = g;
      {e.st, e.z} = dpFunc(bus.req_a[g*FP_W +: FP_W], bus.req_b[g*FP_W +: FP_W], bus.req_rnd[g*3 +: 3]);
      e.rdy = cyc + 1 + int'(LAT);
      q.push_back(e);
      mPtr = (g + 1) % NREQ;
      mOut++;
    end
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    toNeg();
    if (useModel) modelCheck();
    lastGrant = bus.req_ready;
    if (|(bus.req_valid & bus.req_ready)) dutIssues++;
    toPos();
  endtask

  task automatic doReset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
  endtask

  task automatic setOp(input int id, input logic [FP_W-1:0] a, input logic [FP_W-1:0] b,
                       input logic [2:0] r);
    bus.req_a[id*FP_W +: FP_W] = a;
    bus.req_b[id*FP_W +: FP_W] = b;
    bus.req_rnd[id*3 +: 3]     = r;
  endtask

  task automatic randOps();
    logic [FP_W-1:0] a;
    for (int i = 0; i < int'(NREQ); i++) begin
      a = 12'($urandom);
      setOp(i, a, ($urandom % 4 == 0) ? a : 12'($urandom), 3'($urandom));
    end
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int sum;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    dutIssues = 0;
    useModel  = 1'b0;
    lastGrant = '0;
    modelClear();
    bus.req_valid = {NREQ{1'b1}};
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_rnd   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state with all requesters asking
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_dp_valid", 32'(bus.dp_valid), 0);
    chk("rst_dp_a", 32'(bus.dp_a), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_z", 32'(bus.rsp_z), 0);
    doReset();

    // Directed single-op vectors: expected values worked out by hand
    vecs[0] = '{0, 12'h3C0, 12'h3C0, 3'd0, 12'h400, 8'h00};
    vecs[1] = '{1, 12'h400, 12'h400, 3'd1, 12'h440, 8'h00};
    vecs[2] = '{2, 12'h3C0, 12'h400, 3'd2, 12'h3D2, 8'hC2};
    vecs[3] = '{3, 12'hFC1, 12'hFC1, 3'd4, 12'hFC1, 8'h10};
    vecs[4] = '{0, 12'h7C5, 12'h001, 3'd7, 12'h7C5, 8'h10};
    bus.rsp_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      setOp(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].rnd);
      bus.req_valid = '0;
      bus.req_valid[vecs[v].id] = 1'b1;
      toNeg();
      chk("vec_grant", 32'(bus.req_ready), 32'(1) << vecs[v].id);
      toPos();
      bus.req_valid = '0;
      toNeg();
      chk("vec_dp_valid", 32'(bus.dp_valid), 1);
      chk("vec_dp_a", 32'(bus.dp_a), 32'(vecs[v].a));
      chk("vec_dp_b", 32'(bus.dp_b), 32'(vecs[v].b));
      chk("vec_dp_rnd", 32'(bus.dp_rnd), 32'(vecs[v].rnd));
      chk("vec_rsp_early1", 32'(bus.rsp_valid), 0);
      toPos();
      toNeg();
      chk("vec_rsp_early2", 32'(bus.rsp_valid), 0);
      toPos();
      toNeg();
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("vec_rsp_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      chk("vec_rsp_z", 32'(bus.rsp_z), 32'(vecs[v].z));
      chk("vec_rsp_status", 32'(bus.rsp_status), 32'(vecs[v].st));
      toPos();
    end

    // All requesters busy with a free-flowing consumer: strict rotation, one per cycle
    doReset();
    useModel = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = {NREQ{1'b1}};
    for (int c = 0; c < 16; c++) begin
      randOps();
      step();
      chk("rr_grant", 32'(lastGrant), 32'(1) << (c % 4));
    end
    drain();

    // Stalled consumer: credits allow exactly FIFO_D issues, one pop frees one more
    doReset();
    bus.req_valid = 4'b0001;
    dutIssues = 0;
    repeat (8) step();
    chk("credit_issues", 32'(dutIssues), 4);
    chk("credit_ready_low", 32'(lastGrant), 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    repeat (4) step();
    chk("credit_one_more", 32'(dutIssues), 5);
    drain();

    // Wrap-around: pointer at 3, only requester 2 asking
    doReset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    step();
    chk("wrap_first", 32'(lastGrant), 32'h4);
    step();
    chk("wrap_grant", 32'(lastGrant), 32'h4);
    bus.req_valid = 4'b1111;
    step();
    chk("wrap_ptr_after", 32'(lastGrant), 32'h8);
    drain();

    // Reset pulse with two ops still in the datapath
    doReset();
    useModel = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0011;
    step();
    step();
    bus.req_valid = 4'b1111;
    chk("pre_rst_dp_valid", 32'(bus.dp_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_dp_valid", 32'(bus.dp_valid), 0);
    chk("mid_rst_dp_a", 32'(bus.dp_a), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_rsp_id", 32'(bus.rsp_id), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_valid = '0;
    modelClear();
    for (int c = 0; c < 6; c++) begin
      toNeg();
      chk("no_stale_rsp", 32'(bus.rsp_valid), 0);
      toPos();
    end
    useModel = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    dutIssues = 0;
    repeat (8) step();
    chk("post_rst_credits", 32'(dutIssues), 4);
    drain();

    // Randomized traffic and backpressure
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = 4'($urandom);
      randOps();
      bus.rsp_ready = ($urandom % 4) != 0;
      step();
    end
    drain();
    chk("final_queue_empty", 32'(q.size()), 0);

`ifdef R5FP_ADD_ARB_STATS_EN
    // Counters: stalled consumer, everyone asking for ten cycles
    doReset();
    useModel = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (10) step();
    bus.req_valid = '0;
    sum = 0;
    for (int i = 0; i < int'(NREQ); i++) sum += int'(stat_grant[i*16 +: 16]);
    chk("stat_grant_sum", 32'(sum), 4);
    chk("stat_stall", 32'(stat_stall), 6);
`else
    sum = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
